// File: rtl/matrix_stream_rx.sv
// Receive-side decoder for the 16x16 LED matrix serial link: shift/storage emulation,
// row decode, 4-phase density accumulation and a readable committed frame.
// Optional statistics outputs (frame_cnt, err_cnt, lock) are built with MATRIX_STREAM_RX_STATS_EN.
module matrix_stream_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PHASES      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_clk,
  input  logic       serial_data,
  input  logic       rclk,
  input  logic       clear,
  input  logic [3:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [1:0] rd_pix,
  output logic       row_valid,
  output logic [3:0] cur_row,
  output logic [1:0] cur_phase,
  output logic       frame_done,
  output logic       onehot_err,
  output logic       sync_err,
`ifdef MATRIX_STREAM_RX_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic        lock,
`endif
  output logic       len_err
);

  localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

  // Returns {exactly_one_bit_set, index_of_highest_set_bit}.
  function automatic logic [4:0] onehot_decode(input logic [15:0] v);
    logic [4:0] n;
    logic [3:0] idx;
    n   = 5'd0;
    idx = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (v[k]) begin
        n   = n + 5'd1;
        idx = 4'(k);
      end
    end
    return {(n == 5'd1), idx};
  endfunction

  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic b);
    return (a == 2'd3) ? 2'd3 : a + {1'b0, b};
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_r, sdat_sync_r, rclk_sync_r, clr_sync_r;
  logic                   sck_hist_r, rclk_hist_r;
  logic                   sck_rise_s, rclk_rise_s, data_s, clr_n_s;

  logic [31:0] sr_r, store_r;
  logic [5:0]  shift_cnt_r;
  logic        latch_pend_r, len_err_r;

  logic [5:0]  lc_r;
  logic [1:0]  acc_r   [16][16];
  logic [1:0]  frame_r [16][16];
  logic [1:0]  sum_s   [16];
  logic [4:0]  dec_s;
  logic        dec_valid_s;
  logic [3:0]  dec_row_s;
  logic [15:0] lit_s;

  logic       row_valid_r, frame_done_r, onehot_err_r, sync_err_r;
  logic [3:0] cur_row_r;
  logic [1:0] cur_phase_r;

  // Synchronizer chains plus one history flop for rise detection on the clock-like lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_r  <= '0;
      sdat_sync_r <= '0;
      rclk_sync_r <= '0;
      clr_sync_r  <= '0;
      sck_hist_r  <= 1'b0;
      rclk_hist_r <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], serial_clk};
      sdat_sync_r <= {sdat_sync_r[SYNC_STAGES-2:0], serial_data};
      rclk_sync_r <= {rclk_sync_r[SYNC_STAGES-2:0], rclk};
      clr_sync_r  <= {clr_sync_r[SYNC_STAGES-2:0], clear};
      sck_hist_r  <= sck_sync_r[SYNC_STAGES-1];
      rclk_hist_r <= rclk_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_rise_s  = sck_sync_r[SYNC_STAGES-1] & ~sck_hist_r;
  assign rclk_rise_s = rclk_sync_r[SYNC_STAGES-1] & ~rclk_hist_r;
  assign data_s      = sdat_sync_r[SYNC_STAGES-1];
  assign clr_n_s     = clr_sync_r[SYNC_STAGES-1];

  // Shift register, shift counter and storage latch; the latch sees sr before a same-clk shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_r         <= 32'd0;
      store_r      <= 32'd0;
      shift_cnt_r  <= 6'd0;
      latch_pend_r <= 1'b0;
      len_err_r    <= 1'b0;
    end else begin
      if (rclk_rise_s) begin
        store_r      <= sr_r;
        len_err_r    <= (shift_cnt_r != 6'd32);
        latch_pend_r <= 1'b1;
      end else begin
        len_err_r    <= 1'b0;
        latch_pend_r <= 1'b0;
      end
      if (!clr_n_s) begin
        sr_r        <= 32'd0;
        shift_cnt_r <= 6'd0;
      end else if (sck_rise_s) begin
        sr_r        <= {data_s, sr_r[31:1]};
        shift_cnt_r <= rclk_rise_s ? 6'd1 :
                       (shift_cnt_r == 6'd63) ? 6'd63 : shift_cnt_r + 6'd1;
      end else if (rclk_rise_s) begin
        shift_cnt_r <= 6'd0;
      end else begin
        shift_cnt_r <= shift_cnt_r;
      end
    end
  end

  // Decode of the latched word and per-column saturating sums for the addressed row.
  always_comb begin
    dec_s       = onehot_decode(store_r[15:0]);
    dec_valid_s = dec_s[4];
    dec_row_s   = dec_s[3:0];
    lit_s       = ~store_r[31:16];
    for (int c = 0; c < 16; c++) begin
      sum_s[c] = sat_add(acc_r[dec_row_s][c], lit_s[c]);
    end
  end

  // Row processing the clk after a latch: status pulses, latch counter, accumulate and commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lc_r         <= 6'd0;
      row_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      onehot_err_r <= 1'b0;
      sync_err_r   <= 1'b0;
      cur_row_r    <= 4'd0;
      cur_phase_r  <= 2'd0;
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          acc_r[r][c]   <= 2'd0;
          frame_r[r][c] <= 2'd0;
        end
      end
    end else begin
      row_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      onehot_err_r <= 1'b0;
      sync_err_r   <= 1'b0;
      if (latch_pend_r) begin
        if (!dec_valid_s) begin
          onehot_err_r <= 1'b1;
        end else begin
          row_valid_r  <= 1'b1;
          cur_row_r    <= dec_row_s;
          cur_phase_r  <= lc_r[5:4];
          sync_err_r   <= (dec_row_s != lc_r[3:0]);
          frame_done_r <= (lc_r[5:4] == LAST_PHASE) && (dec_row_s == 4'd15);
          // A row mismatch resynchronizes the row count but keeps the phase.
          lc_r         <= {lc_r[5:4], dec_row_s} + 6'd1;
          for (int c = 0; c < 16; c++) begin
            if (lc_r[5:4] == 2'd0) begin
              acc_r[dec_row_s][c] <= {1'b0, lit_s[c]};
            end else if (lc_r[5:4] == LAST_PHASE) begin
              frame_r[dec_row_s][c] <= sum_s[c];
            end else begin
              acc_r[dec_row_s][c] <= sum_s[c];
            end
          end
        end
      end
    end
  end

  assign rd_pix     = frame_r[rd_row][rd_col];
  assign row_valid  = row_valid_r;
  assign cur_row    = cur_row_r;
  assign cur_phase  = cur_phase_r;
  assign frame_done = frame_done_r;
  assign onehot_err = onehot_err_r;
  assign sync_err   = sync_err_r;
  assign len_err    = len_err_r;

`ifdef MATRIX_STREAM_RX_STATS_EN
  logic [15:0] frame_cnt_r, err_cnt_r;
  logic [5:0]  run_r;
  logic        lock_r, taint_r, err_any_s;

  assign err_any_s = onehot_err_r | sync_err_r | len_err_r;

  // Frame/error counters and lock; a length error taints the decode that follows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
      err_cnt_r   <= 16'd0;
      run_r       <= 6'd0;
      lock_r      <= 1'b0;
      taint_r     <= 1'b0;
    end else begin
      if (frame_done_r) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (err_any_s) begin
        err_cnt_r <= err_cnt_r + 16'd1;
        run_r     <= 6'd0;
        lock_r    <= 1'b0;
        taint_r   <= len_err_r;
      end else if (row_valid_r) begin
        if (taint_r) begin
          taint_r <= 1'b0;
        end else if (run_r == 6'd63) begin
          lock_r <= 1'b1;
        end else begin
          run_r <= run_r + 6'd1;
        end
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;
  assign lock      = lock_r;
`endif

endmodule

// File: tb/tb_matrix_stream_rx.sv
// Self-checking bench for matrix_stream_rx: a word/pixel-level model predicts every decode
// event and the committed frame; a negedge monitor compares DUT pulses against it.
module tb_matrix_stream_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_clk, serial_data, rclk, clear;
  logic [3:0] rd_row, rd_col;
  logic [1:0] rd_pix;
  logic       row_valid, frame_done, onehot_err, sync_err, len_err;
  logic [3:0] cur_row;
  logic [1:0] cur_phase;

  matrix_stream_rx dut (
    .clk(clk), .rst(rst), .serial_clk(serial_clk), .serial_data(serial_data),
    .rclk(rclk), .clear(clear), .rd_row(rd_row), .rd_col(rd_col), .rd_pix(rd_pix),
    .row_valid(row_valid), .cur_row(cur_row), .cur_phase(cur_phase),
    .frame_done(frame_done), .onehot_err(onehot_err), .sync_err(sync_err),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    bit sync;
    bit fdone;
    int row;
    int phase;
  } dec_t;

  int   checks = 0, failures = 0;
  dec_t dec_q[$];
  dec_t mon_e;
  bit   hist_q[$];
  int   shifts_m = 0, lc_m = 0, len_exp = 0;
  int   cnt_m[16][16], frame_m[16][16], tgt[16][16];
  int   len_seen = 0, fd_seen = 0, oh_seen = 0, se_seen = 0;
  int   base_fd, base_oh, base_se, base_len;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every decode event must match the next model prediction, in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (len_err)    len_seen++;
      if (frame_done) fd_seen++;
      if (onehot_err) oh_seen++;
      if (sync_err)   se_seen++;
      if (!row_valid) chk("stray_pulse", int'(sync_err | frame_done), 0);
      if (row_valid || onehot_err) begin
        chk("decode_expected", int'(dec_q.size() > 0), 1);
        if (dec_q.size() > 0) begin
          mon_e = dec_q.pop_front();
          chk("row_valid", row_valid, mon_e.valid);
          chk("onehot_err", onehot_err, !mon_e.valid);
          chk("sync_err", sync_err, mon_e.sync);
          chk("frame_done", frame_done, mon_e.fdone);
          if (mon_e.valid) begin
            chk("cur_row", cur_row, mon_e.row);
            chk("cur_phase", cur_phase, mon_e.phase);
          end
        end
      end
    end
  end

  task automatic model_reset();
    hist_q.delete();
    dec_q.delete();
    shifts_m = 0;
    lc_m = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        cnt_m[r][c] = 0;
        frame_m[r][c] = 0;
      end
  endtask

  // Word-level view: the stored word is the last 32 bits shifted since clear/reset.
  task automatic model_latch();
    logic [31:0] w;
    dec_t e;
    int n, row, ph, lit;
    w = 32'd0;
    n = hist_q.size();
    for (int i = 0; i < 32; i++)
      if (n - 32 + i >= 0) w[i] = hist_q[n - 32 + i];
    if (shifts_m != 32) len_exp++;
    shifts_m = 0;
    e = '{valid: 1'b0, sync: 1'b0, fdone: 1'b0, row: 0, phase: 0};
    if ($countones(w[15:0]) == 1) begin
      row = 0;
      for (int k = 0; k < 16; k++) if (w[k]) row = k;
      ph = lc_m / 16;
      e.valid = 1'b1;
      e.row   = row;
      e.phase = ph;
      e.sync  = (row != lc_m % 16);
      e.fdone = (ph == 3) && (row == 15);
      for (int c = 0; c < 16; c++) begin
        lit = w[16 + c] ? 0 : 1;
        if (ph == 0) cnt_m[row][c] = lit;
        else if (ph < 3) cnt_m[row][c] = (cnt_m[row][c] + lit > 3) ? 3 : cnt_m[row][c] + lit;
        else frame_m[row][c] = (cnt_m[row][c] + lit > 3) ? 3 : cnt_m[row][c] + lit;
      end
      lc_m = (ph * 16 + row + 1) % 64;
    end
    dec_q.push_back(e);
  endtask

  task automatic shift_bit(input bit b);
    @(negedge clk) serial_data = b;
    repeat (3) @(negedge clk);
    serial_clk = 1'b1;
    repeat (3) @(negedge clk);
    serial_clk = 1'b0;
    hist_q.push_back(b);
    while (hist_q.size() > 40) void'(hist_q.pop_front());
    shifts_m++;
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) shift_bit(w[i]);
  endtask

  task automatic do_latch();
    model_latch();
    @(negedge clk) rclk = 1'b1;
    repeat (4) @(negedge clk);
    rclk = 1'b0;
    repeat (4) @(negedge clk);
    chk("decode_seen", dec_q.size(), 0);
    chk("len_err_count", len_seen, len_exp);
  endtask

  task automatic send_word(input logic [31:0] w);
    shift_word(w, 32);
    do_latch();
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    repeat (4) @(negedge clk);
    hist_q.delete();
    shifts_m = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  // Driver side of the link: a pixel of level v is lit in phases 0..v-1.
  function automatic logic [31:0] frame_word(input int r, input int p);
    logic [31:0] w;
    w = 32'd0;
    w[r] = 1'b1;
    for (int c = 0; c < 16; c++) w[16 + c] = (p < tgt[r][c]) ? 1'b0 : 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] dark_word(input int r);
    logic [31:0] w;
    w = {16'hFFFF, 16'h0000};
    w[r] = 1'b1;
    return w;
  endfunction

  task automatic run_frame();
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 16; r++) send_word(frame_word(r, p));
  endtask

  task automatic pix_at(input int r, input int c, output int v);
    rd_row = 4'(r);
    rd_col = 4'(c);
    #1 v = rd_pix;
  endtask

  task automatic check_frame();
    int v;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        pix_at(r, c, v);
        chk($sformatf("rd_pix_%0d_%0d", r, c), v, frame_m[r][c]);
      end
  endtask

  initial begin
    int v;
    rst = 1'b1; serial_clk = 1'b0; serial_data = 1'b0; rclk = 1'b0; clear = 1'b1;
    rd_row = 4'd0; rd_col = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("reset_row_valid", row_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_len_err", len_err, 0);
    chk("reset_cur_row", cur_row, 0);
    chk("reset_cur_phase", cur_phase, 0);
    pix_at(5, 5, v);
    chk("reset_pix_5_5", v, 0);

    // Frame A: diagonal 3, anti-diagonal 1.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) tgt[r][c] = (r == c) ? 3 : ((r + c == 15) ? 1 : 0);
    run_frame();
    chk("frameA_done_count", fd_seen, 1);
    chk("frameA_onehot", oh_seen, 0);
    chk("frameA_sync", se_seen, 0);
    chk("frameA_len", len_seen, 0);
    pix_at(5, 5, v);  chk("frameA_pix_5_5", v, 3);
    pix_at(5, 10, v); chk("frameA_pix_5_10", v, 1);
    pix_at(5, 6, v);  chk("frameA_pix_5_6", v, 0);
    check_frame();

    // Non-one-hot anode, then a normal row 0.
    base_oh = oh_seen;
    base_se = se_seen;
    send_word({16'hFFFF, 16'h0003});
    chk("onehot_pulse", oh_seen - base_oh, 1);
    send_word(dark_word(0));
    chk("after_onehot_row", cur_row, 0);
    chk("after_onehot_sync", se_seen - base_se, 0);

    // Row jump 2 -> 5 in phase 0.
    send_word(dark_word(1));
    send_word(dark_word(2));
    send_word(dark_word(5));
    chk("sync_pulse", se_seen - base_se, 1);
    chk("sync_cur_row", cur_row, 5);
    send_word(dark_word(6));
    chk("sync_resumed_at_6", se_seen - base_se, 1);
    chk("sync_cur_phase", cur_phase, 0);

    // Short and long words.
    base_len = len_seen;
    shift_word(dark_word(7), 31);
    do_latch();
    shift_bit(1'b1);
    send_word(dark_word(7));
    chk("len_err_both", len_seen - base_len, 2);
    chk("len_long_row", cur_row, 7);

    // Clear mid-word, then a clean word.
    base_len = len_seen;
    shift_word(32'hFFFF_FFFF, 10);
    pulse_clear();
    send_word(dark_word(8));
    chk("clear_no_len_err", len_seen - base_len, 0);
    chk("clear_row", cur_row, 8);

    // Reset in the middle of frame B, then a full frame B.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) tgt[r][c] = (r + c) % 4;
    for (int r = 0; r < 5; r++) send_word(frame_word(r, 0));
    do_reset();
    pix_at(5, 5, v);
    chk("midreset_pix_5_5", v, 0);
    chk("midreset_cur_row", cur_row, 0);
    base_fd = fd_seen;
    base_oh = oh_seen;
    base_se = se_seen;
    base_len = len_seen;
    len_exp = len_seen;
    run_frame();
    chk("frameB_done_count", fd_seen - base_fd, 1);
    chk("frameB_errors", (oh_seen - base_oh) + (se_seen - base_se) + (len_seen - base_len), 0);
    pix_at(5, 5, v);  chk("frameB_pix_5_5", v, 2);
    pix_at(5, 10, v); chk("frameB_pix_5_10", v, 3);
    pix_at(0, 0, v);  chk("frameB_pix_0_0", v, 0);
    pix_at(0, 1, v);  chk("frameB_pix_0_1", v, 1);
    check_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
